fetch_pc_unit: RTL and testbench
================================

// Module: fetch_pc_unit
// PURPOSE
//  Owns the fetch PC and drives instruction-memory fetch in the IF stage.
//  Selects the next PC from sequential, branch, jump, jump-register and exception targets.
//  The branch target is id_pc_plus4 + br_simm; br_simm is the already-shifted immediate from the ID-stage extender.
//  Buffers a redirect that arrives while imem is not ready, then produces fetch_valid for the IF/ID register.
// PARAMETERS
//  RESET_PC    32'h0040_0000  PC loaded on reset
//  EXC_VECTOR  32'h8000_0180  PC loaded on exception redirect
//  CNT_W       16             width of saturating redirect counter
// PORTS
//  clk           in   1      clock; all state updates on rising edge
//  reset         in   1      synchronous, active-high
//  stall         in   1      hazard unit: hold PC; ID-stage instruction is not final
//  imem_ready    in   1      imem has the instruction for imem_addr this cycle
//  branch_taken  in   1      ID: branch op and condition true
//  br_simm       in   32     ID: sign/zero-extended immediate, already <<2
//  id_pc_plus4   in   32     ID: PC+4 of the instruction in ID
//  jump          in   1      ID: j/jal
//  jump_idx      in   26     ID: instr[25:0]
//  jr            in   1      ID: jr/jalr
//  jr_addr       in   32     ID: forwarded rs value
//  exc_req       in   1      exception redirect; honoured even when stall=1
//  imem_addr     out  32     current fetch PC
//  pc_plus4      out  32     imem_addr + 4, to IF/ID
//  fetch_valid   out  1      imem data is a valid, in-path instruction; IF/ID captures
//  redirect_cnt  out  CNT_W  count of accepted redirects, saturating
// BEHAVIOUR
//  Reset: imem_addr=RESET_PC; pend=0; redirect_cnt=0; fetch_valid=0 in the reset cycle.
//  Reset has priority over every other input, including mid-pending redirects.
//  Redirect request "rq" and its target, in priority order:
//   exc_req                  -> EXC_VECTOR
//   jr & !stall              -> {jr_addr[31:2],2'b00}
//   jump & !stall            -> {id_pc_plus4[31:28],jump_idx,2'b00}
//   branch_taken & !stall    -> id_pc_plus4 + br_simm, mod 2^32
//  There is no delay slot. A wrong-path fetch is suppressed via fetch_valid.
//  State: pend flag plus pend_pc (one entry).
//  Sequencing is a 2-state FSM: RUN (pend=0) and PEND (pend=1).
//  RUN, rq, imem_ready=1:
//   imem_addr <= target; fetch_valid=0.
//  RUN, rq, imem_ready=0:
//   go to PEND; pend_pc <= target; imem_addr held.
//  RUN, no rq, imem_ready=1, !stall:
//   fetch_valid=1; imem_addr <= imem_addr+4.
//  RUN, no rq, stall or !imem_ready:
//   imem_addr held; fetch_valid=0.
//  PEND, imem_ready=0:
//   stay in PEND; a new rq overwrites pend_pc (the newest/highest request wins).
//  PEND, imem_ready=1:
//   fetch_valid=0 (stale fetch dropped).
//   imem_addr <= target if rq, else pend_pc; then go to RUN.
//  redirect_cnt increments once per cycle in which rq=1.
//  The counter holds at all ones (2^CNT_W-1).
//  pc_plus4 = imem_addr + 4 (combinational), 32-bit wrap.
//  All addresses are word aligned; bits [1:0] are forced to 0 on every target.
//  fetch_valid is combinational from state and inputs.
//  Latency: a redirect takes effect 1 cycle after the cycle in which it is accepted.
// TESTING
//  1. Reset, imem_ready=1, no control:
//     -> imem_addr 0x00400000, then 0x00400004, 0x00400008; fetch_valid=1 from cycle 1.
//  2. branch_taken=1, id_pc_plus4=0x00400010, br_simm=0xFFFFFFF8:
//     -> fetch_valid=0 that cycle; next imem_addr=0x00400008; redirect_cnt=1.
//  3. stall=1 with branch_taken=1 and jump=1:
//     -> no redirect, imem_addr held, cnt unchanged.
//     -> Same with exc_req=1 -> next imem_addr=0x80000180.
//  4. imem_ready=0 for 3 cycles; jump with jump_idx=0x0000100 in cycle 1:
//     -> imem_addr held.
//     -> Ready cycle: fetch_valid=0, next addr=0x00000400 (id_pc_plus4[31:28]=0).
//  5. In PEND, jr with jr_addr=0x1234 overwritten by exc_req:
//     -> exit to 0x80000180.
//     -> Then reset mid-PEND -> 0x00400000, pend cleared.
//  6. CNT_W=4, 20 consecutive redirects -> redirect_cnt saturates at 15.
//     Also: id_pc_plus4=0xFFFFFFFC, br_simm=8 -> target 0x00000004.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit
//   Owns the fetch PC for the IF stage. Chooses the next PC from the
//   sequential, branch, jump, jump-register and exception targets. A redirect
//   that arrives while imem is not ready is held in a one-entry pending buffer.
//   fetch_valid tells the IF/ID register when the imem data is an in-path
//   instruction.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   stall               hold PC; the ID-stage instruction is not final
//   imem_ready          imem returns the instruction for imem_addr this cycle
//   branch_taken        ID branch taken; target = id_pc_plus4 + br_simm
//   br_simm             branch offset, already shifted left by 2
//   id_pc_plus4         PC+4 of the instruction in ID
//   jump, jump_idx      j/jal and instr[25:0]
//   jr, jr_addr         jr/jalr and the forwarded rs value
//   exc_req             exception redirect; honoured even while stalled
//   imem_addr           current fetch PC
//   pc_plus4            imem_addr + 4
//   fetch_valid         IF/ID captures the imem data this cycle
//   redirect_cnt        saturating count of accepted redirects
module fetch_pc_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0040_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h8000_0180,
  parameter int          CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             imem_ready,
  input  logic             branch_taken,
  input  logic [31:0]      br_simm,
  input  logic [31:0]      id_pc_plus4,
  input  logic             jump,
  input  logic [25:0]      jump_idx,
  input  logic             jr,
  input  logic [31:0]      jr_addr,
  input  logic             exc_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      pc_plus4,
  output logic             fetch_valid,
  output logic [CNT_W-1:0] redirect_cnt
);

  typedef enum logic {RUN = 1'b0, PEND = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      pend_pc_q, pend_pc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             rq;
  logic [31:0]      target;
  logic [31:0]      br_sum;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign br_sum = id_pc_plus4 + br_simm;

  // Redirect request and target; the exception wins even under stall, the
  // ID-stage redirects only count once the ID instruction is final.
  always_comb begin
    rq     = 1'b0;
    target = pc_q;
    if (exc_req) begin
      rq     = 1'b1;
      target = {EXC_VECTOR[31:2], 2'b00};
    end else if (jr && !stall) begin
      rq     = 1'b1;
      target = {jr_addr[31:2], 2'b00};
    end else if (jump && !stall) begin
      rq     = 1'b1;
      target = {id_pc_plus4[31:28], jump_idx, 2'b00};
    end else if (branch_taken && !stall) begin
      rq     = 1'b1;
      target = {br_sum[31:2], 2'b00};
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pc_q    <= {RESET_PC[31:2], 2'b00};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // The pending target is only meaningful while in PEND, so it needs no reset.
  always_ff @(posedge clk) begin
    pend_pc_q <= pend_pc_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (rq && !imem_ready) state_d = PEND;
      PEND:    if (imem_ready)        state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Output and datapath next-value logic
  always_comb begin
    fetch_valid = 1'b0;
    pc_d        = pc_q;
    pend_pc_d   = pend_pc_q;
    cnt_d       = rq ? sat_inc(cnt_q) : cnt_q;
    case (state_q)
      RUN: begin
        if (rq) begin
          if (imem_ready) pc_d      = target;
          else            pend_pc_d = target;
        end else if (imem_ready && !stall) begin
          fetch_valid = !reset;
          pc_d        = pc_q + 32'd4;
        end
      end
      PEND: begin
        // The fetch returning now is for the stale address: drop it.
        if (imem_ready) pc_d      = rq ? target : pend_pc_q;
        else if (rq)    pend_pc_d = target;
      end
      default: ;
    endcase
  end

  assign imem_addr    = pc_q;
  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_cnt = cnt_q;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, stall, imem_ready, branch_taken, jump, jr, exc_req;
  logic [31:0]      br_simm, id_pc_plus4, jr_addr;
  logic [25:0]      jump_idx;
  logic [31:0]      imem_addr, pc_plus4;
  logic             fetch_valid;
  logic [CNT_W-1:0] redirect_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_pc_unit #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .stall(stall), .imem_ready(imem_ready),
    .branch_taken(branch_taken), .br_simm(br_simm), .id_pc_plus4(id_pc_plus4),
    .jump(jump), .jump_idx(jump_idx), .jr(jr), .jr_addr(jr_addr),
    .exc_req(exc_req), .imem_addr(imem_addr), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .redirect_cnt(redirect_cnt)
  );

  typedef struct {
    logic        rst, stl, rdy, br;
    logic [31:0] simm, idpc4;
    logic        jmp;
    logic [25:0] jidx;
    logic        jrr;
    logic [31:0] jra;
    logic        exc;
    logic [31:0] e_addr;
    logic        e_fv;
    int          e_cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic addv(input logic rst, stl, rdy, br, input logic [31:0] simm, idpc4,
                      input logic jmp, input logic [25:0] jidx, input logic jrr,
                      input logic [31:0] jra, input logic exc,
                      input logic [31:0] e_addr, input logic e_fv, input int e_cnt);
    vec_t v;
    v = '{rst, stl, rdy, br, simm, idpc4, jmp, jidx, jrr, jra, exc, e_addr, e_fv, e_cnt};
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst; stall = v.stl; imem_ready = v.rdy; branch_taken = v.br;
    br_simm = v.simm; id_pc_plus4 = v.idpc4; jump = v.jmp; jump_idx = v.jidx;
    jr = v.jrr; jr_addr = v.jra; exc_req = v.exc;
  endtask

  task automatic chk32(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Compare the pre-edge outputs against a record, then advance one clock.
  task automatic check_step(input string tag, input logic [31:0] e_addr,
                            input logic e_fv, input int e_cnt);
    @(negedge clk);
    chk32({tag, " imem_addr"}, imem_addr, e_addr);
    chk32({tag, " pc_plus4"}, pc_plus4, e_addr + 32'd4);
    chk32({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, e_fv});
    chk32({tag, " redirect_cnt"}, {28'd0, redirect_cnt}, e_cnt[31:0]);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t idle, v;
    idle = '{1'b0, 1'b0, 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 26'd0, 1'b0, 32'd0, 1'b0,
             32'd0, 1'b0, 0};

    //   rst stl rdy br  simm          idpc4         jmp jidx         jr  jra           exc  addr          fv cnt
    // reset and sequential fetch
    addv(1, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400000, 0, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400000, 1, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400004, 1, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400008, 1, 0);
    // backward branch
    addv(0, 0, 1, 1, 32'hFFFFFFF8, 32'h00400010, 0, 26'h0,       0, 32'h0,        0, 32'h0040000C, 0, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400008, 1, 1);
    // stall blocks branch/jump but not exception
    addv(0, 1, 1, 1, 32'h40,       32'h0,        1, 26'h0,       0, 32'h0,        0, 32'h0040000C, 0, 1);
    addv(0, 1, 1, 1, 32'h40,       32'h0,        1, 26'h0,       0, 32'h0,        1, 32'h0040000C, 0, 1);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h80000180, 1, 2);
    // jump while imem not ready for 3 cycles
    addv(0, 0, 0, 0, 32'h0,        32'h00000010, 1, 26'h0000100, 0, 32'h0,        0, 32'h80000184, 0, 2);
    addv(0, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h80000184, 0, 3);
    addv(0, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h80000184, 0, 3);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h80000184, 0, 3);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000400, 1, 3);
    // pending jr overwritten by exception
    addv(0, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       1, 32'h00001237, 0, 32'h00000404, 0, 3);
    addv(0, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        1, 32'h00000404, 0, 4);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000404, 0, 5);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h80000180, 1, 5);
    // pending jr replaced by a branch in the ready cycle
    addv(0, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       1, 32'h00002000, 0, 32'h80000184, 0, 5);
    addv(0, 0, 1, 1, 32'h00000020, 32'h00000100, 0, 26'h0,       0, 32'h0,        0, 32'h80000184, 0, 6);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000120, 1, 7);
    // reset while a jump is pending
    addv(0, 0, 0, 0, 32'h0,        32'h0,        1, 26'h0000200, 0, 32'h0,        0, 32'h00000124, 0, 7);
    addv(1, 0, 0, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000124, 0, 8);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400000, 1, 0);
    addv(0, 1, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400004, 0, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00400004, 1, 0);
    // branch target wraps past 2^32
    addv(0, 0, 1, 1, 32'h00000008, 32'hFFFFFFFC, 0, 26'h0,       0, 32'h0,        0, 32'h00400008, 0, 0);
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000004, 1, 1);
    // jr target alignment and pc_plus4 wrap
    addv(0, 0, 1, 0, 32'h0,        32'h0,        0, 26'h0,       1, 32'hFFFFFFFF, 0, 32'h00000008, 0, 1);
    addv(0, 1, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'hFFFFFFFC, 0, 2);
    // jump keeps the upper nibble of id_pc_plus4
    addv(0, 0, 1, 0, 32'h0,        32'hA0000000, 1, 26'h3FFFFFF, 0, 32'h0,        0, 32'hFFFFFFFC, 0, 2);
    addv(0, 1, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'hAFFFFFFC, 0, 3);
    // jr has priority over jump and branch
    addv(0, 0, 1, 1, 32'h40,       32'h0,        1, 26'h1,       1, 32'h00000500, 0, 32'hAFFFFFFC, 0, 3);
    addv(0, 1, 1, 0, 32'h0,        32'h0,        0, 26'h0,       0, 32'h0,        0, 32'h00000500, 0, 4);

    drive(idle);
    reset = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) begin
      drive(tbl[i]);
      check_step($sformatf("v%0d", i), tbl[i].e_addr, tbl[i].e_fv, tbl[i].e_cnt);
    end

    // Saturating counter: reset, then 20 back-to-back exception redirects.
    v = idle; v.rst = 1'b1;
    drive(v);
    @(posedge clk); #1;
    v = idle; v.exc = 1'b1;
    drive(v);
    check_step("sat0", 32'h00400000, 1'b0, 0);
    for (int k = 1; k < 20; k++) begin
      check_step($sformatf("sat%0d", k), 32'h80000180, 1'b0, (k > 15) ? 15 : k);
    end
    drive(idle);
    check_step("sat_end", 32'h80000180, 1'b1, 15);
    check_step("sat_hold", 32'h80000184, 1'b1, 15);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
